// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the issue-stage op record.
// The ALU_* select macros sit at the top of this file so every later file sees them.
`ifndef CONTROLS_SV
`define CONTROLS_SV
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SLL  4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SRL  4'd6
`define ALU_SRA  4'd7
`define ALU_OR   4'd8
`define ALU_AND  4'd9
`define ALU_B    4'd10
`define ALU_MUL  4'd11
`endif

package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
    logic [31:0] pc;
  } issue_op_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decode: instruction + operands -> issue_op_t.
// ALU_ISSUE_MUL_EN enables decoding of MUL (funct7=0000001, funct3=000).
module alu_issue_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_op_t   op
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] i_imm;
  logic [31:0] u_imm;
  logic [31:0] imm_shamt;
  logic [31:0] rs2_shamt;
  logic        legal;

  assign opc       = instr[6:0];
  assign rd        = instr[11:7];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign i_imm     = {{20{instr[31]}}, instr[31:20]};
  assign u_imm     = {instr[31:12], 12'b0};
  assign imm_shamt = {27'b0, instr[24:20]};
  assign rs2_shamt = {27'b0, rs2_data[4:0]};

  always_comb begin
    // NOTE: every output gets a default first so no path through the cases can infer a latch.
    legal   = 1'b0;
    op      = '0;
    op.sel  = `ALU_ADD;
    op.rd   = rd;
    op.pc   = pc;
    case (opc)
      OPC_OP: begin
        op.a = rs1_data;
        op.b = rs2_data;
        case (f7)
          F7_BASE: begin
            legal = 1'b1;
            case (f3)
              F3_ADD_SUB: op.sel = `ALU_ADD;
              F3_SLL:     begin op.sel = `ALU_SLL; op.b = rs2_shamt; end
              F3_SLT:     op.sel = `ALU_SLT;
              F3_SLTU:    op.sel = `ALU_SLTU;
              F3_XOR:     op.sel = `ALU_XOR;
              F3_SR:      begin op.sel = `ALU_SRL; op.b = rs2_shamt; end
              F3_OR:      op.sel = `ALU_OR;
              F3_AND:     op.sel = `ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (f3 == F3_ADD_SUB) begin
              op.sel = `ALU_SUB;
              legal  = 1'b1;
            end else if (f3 == F3_SR) begin
              op.sel = `ALU_SRA;
              op.b   = rs2_shamt;
              legal  = 1'b1;
            end
          end
          F7_MULDIV: begin
`ifdef ALU_ISSUE_MUL_EN
            if (f3 == F3_ADD_SUB) begin
              op.sel = `ALU_MUL;
              legal  = 1'b1;
            end
`endif
          end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        op.a  = rs1_data;
        op.b  = i_imm;
        legal = 1'b1;
        case (f3)
          F3_ADD_SUB: op.sel = `ALU_ADD;
          F3_SLL: begin
            op.sel = `ALU_SLL;
            op.b   = imm_shamt;
            legal  = (f7 == F7_BASE);
          end
          F3_SLT:  op.sel = `ALU_SLT;
          F3_SLTU: op.sel = `ALU_SLTU;
          F3_XOR:  op.sel = `ALU_XOR;
          F3_SR: begin
            op.b = imm_shamt;
            if (f7 == F7_BASE)     op.sel = `ALU_SRL;
            else if (f7 == F7_ALT) op.sel = `ALU_SRA;
            else                   legal  = 1'b0;
          end
          F3_OR:  op.sel = `ALU_OR;
          F3_AND: op.sel = `ALU_AND;
        endcase
      end
      OPC_LUI: begin
        op.sel = `ALU_B;
        op.b   = u_imm;
        legal  = 1'b1;
      end
      OPC_AUIPC: begin
        op.a  = pc;
        op.b  = u_imm;
        legal = 1'b1;
      end
      default: ;
    endcase
    // Illegal encodings present a harmless ADD of zeros downstream.
    if (!legal) begin
      op.sel = `ALU_ADD;
      op.a   = '0;
      op.b   = '0;
    end
    op.illegal = !legal;
    op.wb_en   = legal && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode feeding a 2-entry skid buffer so in_ready is registered.
// ALU_ISSUE_MUL_EN (see alu_issue_decode) enables MUL decoding.
module alu_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_alu_sel,
  output logic [XLEN-1:0]  out_bus_a,
  output logic [XLEN-1:0]  out_bus_b,
  output logic [4:0]       out_rd,
  output logic             out_wb_en,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_pc
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_BUSY,
    ST_FULL
  } skid_state_e;

  skid_state_e state, state_nxt;
  issue_op_t   dec_op, main_q, skid_q;
  logic        accept, emit;
  logic        load_main_dec, load_main_skid, load_skid;

  alu_issue_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .op       (dec_op)
  );

  // Both handshake qualifiers come straight from state, so neither is combinational on inputs.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          load_main_dec = 1'b1;
          state_nxt     = ST_BUSY;
        end
        ST_BUSY: begin
          if (accept && emit) begin
            load_main_dec = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (emit) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: if (emit) begin
          load_main_skid = 1'b1;
          state_nxt      = ST_BUSY;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 main_q <= '0;
    else if (load_main_dec)  main_q <= dec_op;
    else if (load_main_skid) main_q <= skid_q;
  end

  // NOTE: the skid entry is never observed unless state says FULL, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= dec_op;
  end

  assign out_alu_sel = main_q.sel;
  assign out_bus_a   = main_q.a;
  assign out_bus_b   = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_wb_en   = main_q.wb_en;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule
